tone_detect: RTL and testbench
==============================

TONE_DETECT -- requirements
Module: tone_detect

Interface
REQ-001 Parameter WINDOW_CYCLES, 500_000, clk cycles per measurement window (10 ms at 50 MHz).
REQ-002 Parameter MIN_EDGES, 20, rising edges in one window for a channel to count as active.
REQ-003 Parameter CONFIRM_WINDOWS, 3, consecutive matching windows before a command locks (legal range 2..15).
REQ-004 Parameter RELEASE_WINDOWS, 2, consecutive non-matching windows before a locked command drops (legal range 1..15).
REQ-005 clk  in  1  single 50 MHz system clock; all logic on posedge clk.
REQ-006 rstN  in  1  reset, synchronous, active-low.
REQ-007 bp1..bp4  in  1 each  asynchronous band-pass comparator outputs for STRAIGHT, LEFT, RIGHT, BACK tones.
REQ-008 bp5  in  1  asynchronous band-pass comparator output for the cancel tone.
REQ-009 tdEn  out  1  high while a direction command is locked.
REQ-010 tdDir  out  2  locked direction: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK.
REQ-011 tdNew  out  1  one-cycle pulse on the cycle tdEn rises.

Function
REQ-012 Each bp input SHALL pass a 2-flop synchronizer, then a rising-edge detector (one-cycle pulse per 0->1).
REQ-013 Each channel SHALL count edge pulses in an 8-bit counter saturating at 255.
REQ-014 A free-running window counter SHALL count 0..WINDOW_CYCLES-1 and wrap; the cycle at WINDOW_CYCLES-1 is the window end.
REQ-015 An edge pulse on the window-end cycle SHALL count toward the ending window; all edge counters clear on the following cycle.
REQ-016 At window end, channel k SHALL be active iff its count, including any window-end edge, is >= MIN_EDGES.
REQ-017 Decode: cancel = bp5 active; valid = cancel low and exactly one of bp1..bp4 active, dir = its code; otherwise none. Two or more active direction channels decode as none.
REQ-018 FSM states IDLE, CANDIDATE, LOCKED; transitions occur only on window-end cycles; outputs are registered and visible the cycle after window end.
REQ-019 IDLE: valid -> CANDIDATE, candDir = dir, match = 1; otherwise stay.
REQ-020 CANDIDATE: valid with dir == candDir -> match+1; at match == CONFIRM_WINDOWS -> LOCKED. Valid with a different dir -> stay, candDir = dir, match = 1. None or cancel -> IDLE, match = 0.
REQ-021 Entering LOCKED: tdEn = 1, tdDir = candDir, tdNew = 1 for exactly one cycle, miss = 0.
REQ-022 LOCKED: valid with dir == tdDir -> miss = 0. Valid with a different dir, or none -> miss+1; at miss == RELEASE_WINDOWS -> IDLE, tdEn = 0.
REQ-023 LOCKED: cancel -> IDLE immediately at that window end, tdEn = 0, regardless of miss.
REQ-024 tdDir SHALL hold the last locked value outside LOCKED. It changes only on entry to LOCKED.
REQ-025 match and miss counters SHALL be 4 bits and SHALL never wrap.

Reset
REQ-026 While rstN is low at a clk edge: FSM = IDLE; window, edge, match and miss counters = 0; synchronizer flops = 0; tdEn = 0, tdDir = 00, tdNew = 0.
REQ-027 Reset asserted mid-window or in LOCKED SHALL drop tdEn on the next edge. The first window after release SHALL be a full WINDOW_CYCLES long.

Structure
REQ-028 The direction encodings STRAIGHT/LEFT/RIGHT/BACK and the FSM state encodings SHALL live in a shared package/include tone_pkg, used by both this block and its consumer.
REQ-029 A sub-module tone_channel SHALL hold the synchronizer, edge detector and saturating counter for one channel, instantiated five times. Its inputs are clk, rstN, the bp input and the window-clear strobe; its output is the count.

Verification (bench overrides: WINDOW_CYCLES=100, MIN_EDGES=4, CONFIRM_WINDOWS=3, RELEASE_WINDOWS=2)
REQ-030 bp2 toggling at 10-cycle period for 4 windows -> tdEn rises one cycle after the end of window 3, tdDir = 01, tdNew high exactly one cycle.
REQ-031 bp1 and bp3 both at 10-cycle period -> tdEn stays 0 for 10 windows.
REQ-032 Lock on bp4 (tdDir = 11), then stop bp4 -> tdEn stays high after 1 silent window and falls after the 2nd; tdDir stays 11.
REQ-033 Lock on bp1, then 1 window with bp5 at 10-cycle period -> tdEn falls one cycle after that window end.
REQ-034 bp3 for 2 windows, then bp2 for 3 windows -> no lock after the bp3 windows; lock with tdDir = 01 after the 3rd bp2 window.
REQ-035 Edge counting and reset:
- Exactly 3 edges in a window -> channel inactive; exactly 4 edges, the last on the window-end cycle -> channel active.
- rstN low for 1 cycle while LOCKED -> tdEn = 0 the next cycle.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared encodings for the tone detector and its consumers: direction codes,
// FSM states and counter widths.
package tone_pkg;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LOCK_CNT_W = 4;
    localparam int unsigned NUM_CH     = 5;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } tdDir_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_CANDIDATE = 2'b01,
        ST_LOCKED    = 2'b10
    } tdState_e;

    // Saturating increment for the match/miss counters.
    function automatic logic [LOCK_CNT_W-1:0] satInc(input logic [LOCK_CNT_W-1:0] v);
        return (v == '1) ? v : v + LOCK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One band-pass channel: 2-flop synchronizer, rising-edge detector and a
// saturating per-window edge counter.
module tone_channel
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rstN,
    input  logic             bp,
    input  logic             winClr,
    output logic [CNT_W-1:0] count_c
);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             edgePulse;
    logic [CNT_W-1:0] cntQ;

    assign edgePulse = sync2 & ~prev;

    // Count includes this cycle's edge so the window-end decision sees it;
    // on the clear cycle the old window's total is dropped.
    always_comb begin
        count_c = winClr ? CNT_W'(edgePulse) : cntQ;
        if (!winClr && edgePulse && (cntQ != '1)) begin
            count_c = cntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            cntQ  <= '0;
        end else begin
            sync1 <= bp;
            sync2 <= sync1;
            prev  <= sync2;
            cntQ  <= count_c;
        end
    end

endmodule

// File: rtl/tone_detect.sv
// Tone command detector: measures edge rates on five band-pass channels per
// window and locks a direction after consecutive matching windows.
module tone_detect
    import tone_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES   = 500_000,
    parameter int unsigned MIN_EDGES       = 20,
    parameter int unsigned CONFIRM_WINDOWS = 3,
    parameter int unsigned RELEASE_WINDOWS = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       bp1,
    input  logic       bp2,
    input  logic       bp3,
    input  logic       bp4,
    input  logic       bp5,
    output logic       tdEn,
    output logic [1:0] tdDir,
    output logic       tdNew
);

    localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic [WIN_W-1:0]      winCnt;
    logic                  winEnd_c;
    logic                  winClr;
    logic [NUM_CH-1:0]     bpVec;
    logic [NUM_CH-1:0]     active_c;
    logic [CNT_W-1:0]      chCount [NUM_CH];

    logic                  cancel_c;
    logic                  valid_c;
    tdDir_e                dir_c;

    tdState_e              stateQ, stateN;
    tdDir_e                candDirQ, candDirN;
    logic [LOCK_CNT_W-1:0] matchQ, matchN, matchInc;
    logic [LOCK_CNT_W-1:0] missQ, missN, missInc;
    logic                  tdEnN;
    logic [1:0]            tdDirN;
    logic                  tdNewN;

    assign bpVec    = {bp5, bp4, bp3, bp2, bp1};
    assign winEnd_c = (winCnt == WIN_W'(WINDOW_CYCLES - 1));

    // Free-running window timer; edge counters clear the cycle after window end.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            winCnt <= '0;
            winClr <= 1'b0;
        end else begin
            winCnt <= winEnd_c ? '0 : winCnt + WIN_W'(1);
            winClr <= winEnd_c;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : gChan
        tone_channel uChan (
            .clk    (clk),
            .rstN   (rstN),
            .bp     (bpVec[i]),
            .winClr (winClr),
            .count_c(chCount[i])
        );
        assign active_c[i] = (chCount[i] >= CNT_W'(MIN_EDGES));
    end

    // Exactly one active direction channel and no cancel makes a valid command.
    always_comb begin
        cancel_c = active_c[4];
        valid_c  = 1'b0;
        dir_c    = DIR_STRAIGHT;
        case (active_c[3:0])
            4'b0001: begin valid_c = 1'b1; dir_c = DIR_STRAIGHT; end
            4'b0010: begin valid_c = 1'b1; dir_c = DIR_LEFT;     end
            4'b0100: begin valid_c = 1'b1; dir_c = DIR_RIGHT;    end
            4'b1000: begin valid_c = 1'b1; dir_c = DIR_BACK;     end
            default: ;
        endcase
        if (cancel_c) begin
            valid_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            stateQ   <= ST_IDLE;
            candDirQ <= DIR_STRAIGHT;
            matchQ   <= '0;
            missQ    <= '0;
            tdEn     <= 1'b0;
            tdDir    <= 2'b00;
            tdNew    <= 1'b0;
        end else begin
            stateQ   <= stateN;
            candDirQ <= candDirN;
            matchQ   <= matchN;
            missQ    <= missN;
            tdEn     <= tdEnN;
            tdDir    <= tdDirN;
            tdNew    <= tdNewN;
        end
    end

    // Next-state logic; only window-end cycles move the FSM.
    always_comb begin
        stateN   = stateQ;
        candDirN = candDirQ;
        matchN   = matchQ;
        missN    = missQ;
        tdEnN    = tdEn;
        tdDirN   = tdDir;
        tdNewN   = 1'b0;
        matchInc = satInc(matchQ);
        missInc  = satInc(missQ);

        if (winEnd_c) begin
            case (stateQ)
                ST_IDLE: begin
                    if (valid_c) begin
                        stateN   = ST_CANDIDATE;
                        candDirN = dir_c;
                        matchN   = LOCK_CNT_W'(1);
                    end
                end
                ST_CANDIDATE: begin
                    if (valid_c && (dir_c == candDirQ)) begin
                        if (matchInc == LOCK_CNT_W'(CONFIRM_WINDOWS)) begin
                            stateN = ST_LOCKED;
                            matchN = '0;
                            missN  = '0;
                            tdEnN  = 1'b1;
                            tdDirN = candDirQ;
                            tdNewN = 1'b1;
                        end else begin
                            matchN = matchInc;
                        end
                    end else if (valid_c) begin
                        candDirN = dir_c;
                        matchN   = LOCK_CNT_W'(1);
                    end else begin
                        stateN = ST_IDLE;
                        matchN = '0;
                    end
                end
                ST_LOCKED: begin
                    if (cancel_c) begin
                        stateN = ST_IDLE;
                        missN  = '0;
                        tdEnN  = 1'b0;
                    end else if (valid_c && (dir_c == tdDir)) begin
                        missN = '0;
                    end else if (missInc == LOCK_CNT_W'(RELEASE_WINDOWS)) begin
                        stateN = ST_IDLE;
                        missN  = '0;
                        tdEnN  = 1'b0;
                    end else begin
                        missN = missInc;
                    end
                end
                default: stateN = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_detect.sv
// Directed bench for tone_detect with short windows (100 cycles, 4 edges).
module tb_tone_detect;

    logic       clk = 1'b0;
    logic       rstN;
    logic       bp1, bp2, bp3, bp4, bp5;
    logic       tdEn;
    logic [1:0] tdDir;
    logic       tdNew;

    int testCnt = 0;
    int failCnt = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    tone_detect #(
        .WINDOW_CYCLES  (100),
        .MIN_EDGES      (4),
        .CONFIRM_WINDOWS(3),
        .RELEASE_WINDOWS(2)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bp1  (bp1),
        .bp2  (bp2),
        .bp3  (bp3),
        .bp4  (bp4),
        .bp5  (bp5),
        .tdEn (tdEn),
        .tdDir(tdDir),
        .tdNew(tdNew)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic en, input logic [1:0] dir, input logic nw);
        check({tag, ".tdEn"},  {3'b0, tdEn},  {3'b0, en});
        check({tag, ".tdDir"}, {2'b0, tdDir}, {2'b0, dir});
        check({tag, ".tdNew"}, {3'b0, tdNew}, {3'b0, nw});
    endtask

    // Drive inputs, then advance to just past the next rising edge.
    task automatic stepVal(input logic [5:1] v);
        {bp5, bp4, bp3, bp2, bp1} = v;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // 10-cycle square wave on the masked inputs, aligned to the window phase.
    task automatic stepTone(input logic [5:1] mask);
        int ph;
        ph = cyc % 100;
        stepVal((((ph / 5) % 2) == 1) ? mask : 5'b0);
    endtask

    task automatic toneWindow(input logic [5:1] mask);
        for (int i = 0; i < 100; i++) stepTone(mask);
    endtask

    // bp1 gets 3 edges mid-window, plus a 4th landing on the window-end cycle.
    task automatic pulseWindow(input bit lastAtEnd);
        for (int p = 0; p < 100; p++) begin
            logic b;
            b = (p == 10) || (p == 11) || (p == 30) || (p == 31) || (p == 50) || (p == 51)
                || (lastAtEnd && (p >= 97));
            stepVal({4'b0, b});
        end
    endtask

    initial begin
        rstN = 1'b0;
        repeat (3) stepVal(5'b0);
        checkOut("reset", 1'b0, 2'b00, 1'b0);
        rstN = 1'b1;
        cyc  = 0;

        // bp2 for 4 windows: lock LEFT at end of window 3
        toneWindow(5'b00010);
        checkOut("left.w1", 1'b0, 2'b00, 1'b0);
        toneWindow(5'b00010);
        checkOut("left.w2", 1'b0, 2'b00, 1'b0);
        toneWindow(5'b00010);
        checkOut("left.w3", 1'b1, 2'b01, 1'b1);
        stepTone(5'b00010);
        checkOut("left.w3+1", 1'b1, 2'b01, 1'b0);
        for (int i = 1; i < 100; i++) stepTone(5'b00010);
        checkOut("left.w4", 1'b1, 2'b01, 1'b0);
        toneWindow(5'b00000);
        checkOut("left.miss1", 1'b1, 2'b01, 1'b0);
        toneWindow(5'b00000);
        checkOut("left.miss2", 1'b0, 2'b01, 1'b0);

        // bp1 and bp3 together never decode
        for (int w = 0; w < 10; w++) begin
            toneWindow(5'b00101);
            check($sformatf("dual.w%0d.tdEn", w + 1), {3'b0, tdEn}, 4'd0);
        end

        // lock BACK, then two silent windows release it
        toneWindow(5'b01000);
        toneWindow(5'b01000);
        checkOut("back.w2", 1'b0, 2'b01, 1'b0);
        toneWindow(5'b01000);
        checkOut("back.lock", 1'b1, 2'b11, 1'b1);
        toneWindow(5'b00000);
        checkOut("back.silent1", 1'b1, 2'b11, 1'b0);
        toneWindow(5'b00000);
        checkOut("back.silent2", 1'b0, 2'b11, 1'b0);

        // lock STRAIGHT, then a cancel window drops it at that window end
        repeat (3) toneWindow(5'b00001);
        checkOut("str.lock", 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 99; i++) stepTone(5'b10000);
        checkOut("cancel.pre", 1'b1, 2'b00, 1'b0);
        stepTone(5'b10000);
        checkOut("cancel.end", 1'b0, 2'b00, 1'b0);

        // RIGHT candidate replaced by LEFT, which then locks
        toneWindow(5'b00100);
        checkOut("swap.r1", 1'b0, 2'b00, 1'b0);
        toneWindow(5'b00100);
        checkOut("swap.r2", 1'b0, 2'b00, 1'b0);
        toneWindow(5'b00010);
        toneWindow(5'b00010);
        checkOut("swap.l2", 1'b0, 2'b00, 1'b0);
        toneWindow(5'b00010);
        checkOut("swap.l3", 1'b1, 2'b01, 1'b1);

        // one-cycle reset while locked
        repeat (10) stepTone(5'b00010);
        rstN = 1'b0;
        stepTone(5'b00010);
        checkOut("rst.locked", 1'b0, 2'b00, 1'b0);
        rstN = 1'b1;
        cyc  = 0;

        // 3 edges is inactive; 4 with the last on the window-end cycle is active
        toneWindow(5'b00001);
        toneWindow(5'b00001);
        pulseWindow(1'b0);
        checkOut("edge3", 1'b0, 2'b00, 1'b0);
        toneWindow(5'b00001);
        toneWindow(5'b00001);
        checkOut("edge.pre", 1'b0, 2'b00, 1'b0);
        pulseWindow(1'b1);
        checkOut("edge4", 1'b1, 2'b00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
